// File: rtl/bk16_addsub_pipe.sv
// bk16_addsub_pipe: two-stage pipelined 16-bit add/subtract unit.
// Structure: Brent-Kung 4-bit groups with a 4-group carry lookahead.
//   Stage 1 registers the bit p/g, the group P/G, c0 and the op type.
//   Stage 2 resolves the group carries and the bit carries, then registers
//   the result and its flags.
// Optional feature: define BK16_SAT_EN to clamp out_s on signed overflow.
//   The clamp is 7FFF for positive overflow and 8000 for negative overflow.
// Ports:
//   clk, rst           rising-edge clock; synchronous active-high reset
//   in_valid/in_ready  operand handshake; in_ready depends on out_ready
//   in_a, in_b         16-bit operands
//   in_sub             0: a+b+cb; 1: a-b-cb
//   in_cb              carry-in (add) or borrow-in (sub)
//   out_valid/out_ready  result handshake
//   out_s              16-bit sum or difference
//   out_cb             carry-out (add) or borrow-out (sub)
//   out_ovf            signed overflow
//   out_zero           out_s == 0
module bk16_addsub_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   input  logic        in_sub,
   input  logic        in_cb,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_s,
   output logic        out_cb,
   output logic        out_ovf,
   output logic        out_zero
);

   localparam int unsigned W  = 16;
   localparam int unsigned GW = 4;
   localparam int unsigned NG = W / GW;

   // Stage-1 combinational signals
   logic [W-1:0]             b_eff_c, p_c, g_c;
   logic [NG-1:0]            grp_p_c, grp_g_c;
   logic [NG-1:0][GW-2:0]    g_lo_c;

   // Stage-1 registers
   logic                     s1_valid;
   logic [W-1:0]             s1_p;
   logic [NG-1:0][GW-2:0]    s1_g;   // the top bit g of each group only feeds G
   logic [NG-1:0]            s1_gp, s1_gg;
   logic                     s1_c0, s1_sub;
`ifdef BK16_SAT_EN
   logic                     s1_a_msb;
`endif

   // Stage-2 combinational signals
   logic [NG:0]              gc_c;   // group carries C0..C4
   logic [W-1:0]             c_c;    // carry into each bit
   logic [W-1:0]             sum_c, s_fin_c;
   logic                     ovf_c, cb_c, zero_c;

   logic                     s2_valid, s1_adv, s2_adv;

   // Advance when the stage ahead is empty or draining
   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   // Subtraction is a + ~b + 1; the borrow-in then inverts the carry-in
   assign b_eff_c = in_sub ? ~in_b : in_b;
   assign p_c     = in_a ^ b_eff_c;
   assign g_c     = in_a & b_eff_c;

   // Per-group P and Brent-Kung G: (3:2) and (1:0) pairs, then the combine
   for (genvar k = 0; k < NG; k++) begin : g_s1_grp
      localparam int unsigned B = GW * k;
      assign grp_p_c[k] = &p_c[B +: GW];
      assign grp_g_c[k] = (g_c[B+3] | (p_c[B+3] & g_c[B+2]))
                        | ((p_c[B+3] & p_c[B+2]) & (g_c[B+1] | (p_c[B+1] & g_c[B])));
      assign g_lo_c[k]  = g_c[B +: GW-1];
   end

   // Stage-1 payload; only loaded on a real beat
   always_ff @(posedge clk) begin
      if (s1_adv && in_valid) begin
         s1_p   <= p_c;
         s1_g   <= g_lo_c;
         s1_gp  <= grp_p_c;
         s1_gg  <= grp_g_c;
         s1_c0  <= in_sub ^ in_cb;
         s1_sub <= in_sub;
`ifdef BK16_SAT_EN
         s1_a_msb <= in_a[W-1];
`endif
      end
   end

   // Two-level group carry lookahead
   assign gc_c[0] = s1_c0;
   assign gc_c[1] = s1_gg[0] | (s1_gp[0] & s1_c0);
   assign gc_c[2] = s1_gg[1] | (s1_gp[1] & s1_gg[0]) | (s1_gp[1] & s1_gp[0] & s1_c0);
   assign gc_c[3] = s1_gg[2] | (s1_gp[2] & s1_gg[1]) | (s1_gp[2] & s1_gp[1] & s1_gg[0])
                  | (s1_gp[2] & s1_gp[1] & s1_gp[0] & s1_c0);
   assign gc_c[4] = s1_gg[3] | (s1_gp[3] & s1_gg[2]) | (s1_gp[3] & s1_gp[2] & s1_gg[1])
                  | (s1_gp[3] & s1_gp[2] & s1_gp[1] & s1_gg[0])
                  | (s1_gp[3] & s1_gp[2] & s1_gp[1] & s1_gp[0] & s1_c0);

   // In-group prefix seeded with each group's carry-in
   for (genvar k = 0; k < NG; k++) begin : g_s2_grp
      localparam int unsigned B = GW * k;
      assign c_c[B]   = gc_c[k];
      assign c_c[B+1] = s1_g[k][0] | (s1_p[B] & gc_c[k]);
      assign c_c[B+2] = s1_g[k][1] | (s1_p[B+1] & s1_g[k][0])
                      | (s1_p[B+1] & s1_p[B] & gc_c[k]);
      assign c_c[B+3] = s1_g[k][2] | (s1_p[B+2] & s1_g[k][1])
                      | (s1_p[B+2] & s1_p[B+1] & s1_g[k][0])
                      | (s1_p[B+2] & s1_p[B+1] & s1_p[B] & gc_c[k]);
   end

   assign sum_c = s1_p ^ c_c;
   assign ovf_c = c_c[W-1] ^ gc_c[NG];
   assign cb_c  = s1_sub ^ gc_c[NG];

`ifdef BK16_SAT_EN
   // Clamp direction follows the sign of a: overflow always moves away from it
   assign s_fin_c = ovf_c ? (s1_a_msb ? 16'h8000 : 16'h7FFF) : sum_c;
`else
   assign s_fin_c = sum_c;
`endif
   assign zero_c = (s_fin_c == '0);

   // Valid bits and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         out_s    <= '0;
         out_cb   <= 1'b0;
         out_ovf  <= 1'b0;
         out_zero <= 1'b0;
      end else begin
         if (s1_adv) s1_valid <= in_valid;
         if (s2_adv) s2_valid <= s1_valid;
         if (s2_adv && s1_valid) begin
            out_s    <= s_fin_c;
            out_cb   <= cb_c;
            out_ovf  <= ovf_c;
            out_zero <= zero_c;
         end
      end
   end

endmodule

// File: tb/tb_bk16_addsub_pipe.sv
// Scoreboard bench for bk16_addsub_pipe: the driver pushes expected results on
// accept; the monitor pops and compares on every out_valid & out_ready.
module tb_bk16_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_sub, in_cb;
   logic        out_valid, out_ready, out_cb, out_ovf, out_zero;
   logic [15:0] in_a, in_b, out_s;

   always #5 clk = ~clk;

   bk16_addsub_pipe dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cb(in_cb),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s(out_s), .out_cb(out_cb), .out_ovf(out_ovf), .out_zero(out_zero)
   );

   typedef struct packed {
      logic [15:0] s;
      logic        cb;
      logic        ovf;
      logic        zero;
   } exp_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic        cb;
      exp_t        e;
   } vec_t;

   exp_t sb[$];
   int   checks = 0, failures = 0, n_acc = 0, n_out = 0;
   logic rand_done = 1'b0;

   // Reference: plain 17-bit arithmetic plus the sign rule for overflow
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input logic cb);
      logic [16:0] r;
      exp_t        e;
      if (!sub) begin
         r     = {1'b0, a} + {1'b0, b} + 17'(cb);
         e.ovf = (a[15] == b[15]) && (r[15] != a[15]);
      end else begin
         r     = {1'b0, a} - {1'b0, b} - 17'(cb);
         e.ovf = (a[15] != b[15]) && (r[15] != a[15]);
      end
      e.cb = r[16];
      e.s  = r[15:0];
`ifdef BK16_SAT_EN
      if (e.ovf) e.s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
      e.zero = (e.s == 16'h0000);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic chk_res(input string name, input exp_t got, input exp_t req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s actual s=%h cb=%b ovf=%b zero=%b required s=%h cb=%b ovf=%b zero=%b",
                  name, got.s, got.cb, got.ovf, got.zero, req.s, req.cb, req.ovf, req.zero);
      end
   endtask

   // Monitor: in-order scoreboard compare, plus hold-stability while stalled
   exp_t held, got, e_pop;
   logic held_v = 1'b0;
   always @(negedge clk) begin
      got = {out_s, out_cb, out_ovf, out_zero};
      if (rst) begin
         held_v = 1'b0;
      end else if (out_valid) begin
         if (out_ready) begin
            held_v = 1'b0;
            n_out++;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_result actual s=%h required none", got.s);
            end else begin
               e_pop = sb.pop_front();
               chk_res("result", got, e_pop);
            end
         end else begin
            if (held_v) chk_res("stall_hold", got, held);
            held   = got;
            held_v = 1'b1;
         end
      end else begin
         held_v = 1'b0;
      end
   end

   // Drive one beat; hold it until accepted (bounded)
   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cb, input exp_t e);
      int   budget = 60;
      logic acc    = 1'b0;
      in_a = a; in_b = b; in_sub = sub; in_cb = cb; in_valid = 1'b1;
      while (!acc && budget > 0) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) begin
            sb.push_back(e);
            n_acc++;
         end
         @(posedge clk);
         #1;
         budget--;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=no_accept required=accept");
      end
   endtask

   task automatic drain();
      int budget = 300;
      while (sb.size() != 0 && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_s"},     32'(out_s),     32'd0);
      chk({tag, "_out_cb"},    32'(out_cb),    32'd0);
      chk({tag, "_out_ovf"},   32'(out_ovf),   32'd0);
      chk({tag, "_out_zero"},  32'(out_zero),  32'd0);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
   endtask

   // Hand-computed vectors: {a, b, sub, cb, {s, cb, ovf, zero}}
   vec_t dv[12];
   initial begin
      dv[0]  = {16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
      dv[1]  = {16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      dv[2]  = {16'h0005, 16'h0004, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
`ifdef BK16_SAT_EN
      dv[3]  = {16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
      dv[4]  = {16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      dv[7]  = {16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
      dv[9]  = {16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      dv[11] = {16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
`else
      dv[3]  = {16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      dv[4]  = {16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
      dv[7]  = {16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
      dv[9]  = {16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
      dv[11] = {16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h4B4B, 1'b0, 1'b1, 1'b0};
`endif
      dv[5]  = {16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      dv[6]  = {16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      dv[8]  = {16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
      dv[10] = {16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0};
   end

   // Hang guard
   initial begin
      #800000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, o0;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cb = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_reset_state("reset");

      // Latency: accepted on edge N (in_valid high in that cycle), visible after N+1
      send(dv[0].a, dv[0].b, dv[0].sub, dv[0].cb, dv[0].e);
      chk("latency_s1", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("latency_s2", 32'(out_valid), 32'd1);
      chk("latency_s", 32'(out_s), 32'h5555);
      drain();

      // Directed table back-to-back
      for (int i = 1; i < 12; i++) send(dv[i].a, dv[i].b, dv[i].sub, dv[i].cb, dv[i].e);
      drain();

      // Backpressure: 5 beats against a stalled output
      out_ready = 1'b0;
      n0 = n_acc;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               logic [15:0] a;
               a = 16'(16'h0110 * (i + 1));
               send(a, 16'h0001, 1'b0, 1'b0, model(a, 16'h0001, 1'b0, 1'b0));
            end
         end
         begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk("bp_accepts", 32'(n_acc - n0), 32'd2);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_all_accepted", 32'(n_acc - n0), 32'd5);

      // Reset with two beats in flight: they must never surface
      out_ready = 1'b0;
      send(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
      send(16'h3333, 16'h0001, 1'b1, 1'b0, model(16'h3333, 16'h0001, 1'b1, 1'b0));
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_reset_state("midrst");
      out_ready = 1'b1;
      o0 = n_out;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_no_output", 32'(n_out - o0), 32'd0);
      send(16'h0100, 16'h0023, 1'b0, 1'b0, model(16'h0100, 16'h0023, 1'b0, 1'b0));
      chk("midrst_lat_s1", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("midrst_lat_s2", 32'(out_valid), 32'd1);
      drain();

      // Random operands with random backpressure and input gaps
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               logic [15:0] ra, rb;
               logic        rs, rc;
               ra = 16'($urandom); rb = 16'($urandom);
               rs = 1'($urandom);  rc = 1'($urandom);
               if ($urandom_range(0, 4) == 0) begin
                  in_a = 16'($urandom);
                  in_b = 16'($urandom);
                  @(posedge clk);
                  #1;
               end
               send(ra, rb, rs, rc, model(ra, rb, rs, rc));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
